// File: rtl/spi_slave_wb.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_wb
// Description : Mode-0 SPI slave with a Wishbone register file. Assembles
//               32-bit MSB-first words into an RX FIFO and shifts a CPU-loaded
//               TX word out on MISO. Optional macro: SPI_SLAVE_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_wb #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_sclk,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam logic [DEPTH_LOG2:0] c_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [1:0]          c_RXDATA  = 2'd0;
  localparam logic [1:0]          c_TXDATA  = 2'd1;
  localparam logic [1:0]          c_STATUS  = 2'd2;
  localparam logic [1:0]          c_CTRL    = 2'd3;

  // ---------------------------------------------------------------- sync
  logic [2:0] r_cs_sy;
  logic [2:0] r_sclk_sy;
  logic [2:0] r_mosi_sy;
  logic [1:0] r_settle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_sy   <= 3'b000;
      r_sclk_sy <= 3'b000;
      r_mosi_sy <= 3'b000;
      r_settle  <= 2'd0;
    end else begin
      r_cs_sy   <= {r_cs_sy[1:0], i_cs};
      r_sclk_sy <= {r_sclk_sy[1:0], i_sclk};
      r_mosi_sy <= {r_mosi_sy[1:0], i_mosi};
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  // Edges are masked until the cleared pipeline has refilled, so a pin held
  // high through reset is not mistaken for a fresh chip-select rise.
  logic w_live, w_cs, w_mosi;
  logic w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;

  assign w_live      = (r_settle == 2'd3);
  assign w_cs        = r_cs_sy[1];
  assign w_mosi      = r_mosi_sy[1];
  assign w_cs_rise   = w_live &  r_cs_sy[1]   & ~r_cs_sy[2];
  assign w_cs_fall   = w_live & ~r_cs_sy[1]   &  r_cs_sy[2];
  assign w_sclk_rise = w_live &  r_sclk_sy[1] & ~r_sclk_sy[2];
  assign w_sclk_fall = w_live & ~r_sclk_sy[1] &  r_sclk_sy[2];

  logic r_armed;
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_armed <= 1'b0;
    else if (w_cs_fall) r_armed <= 1'b0;
    else if (w_cs_rise) r_armed <= 1'b1;
  end

  logic w_rx_bit, w_tx_fall;
  assign w_rx_bit  = r_armed & w_cs & w_sclk_rise;
  assign w_tx_fall = r_armed & w_cs & w_sclk_fall;

  // ---------------------------------------------------------------- RX
  logic [31:0] r_rx_shift;
  logic [4:0]  r_bit_cnt;
  logic        r_push_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_shift  <= 32'h0;
      r_bit_cnt   <= 5'd0;
      r_push_pend <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      if (w_cs_fall || w_cs_rise) begin
        r_bit_cnt <= 5'd0;
      end else if (w_rx_bit) begin
        r_rx_shift <= {r_rx_shift[30:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == 5'd31) r_push_pend <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- bus decode
  logic       r_ack;
  logic [1:0] w_sel;
  logic       w_req, w_wr_tx, w_wr_ctrl, w_rd_rx;

  assign w_sel     = i_wb_adr[3:2];
  assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_wr_tx   = w_req &  i_wb_we & (w_sel == c_TXDATA);
  assign w_wr_ctrl = w_req &  i_wb_we & (w_sel == c_CTRL);
  assign w_rd_rx   = w_req & ~i_wb_we & (w_sel == c_RXDATA);

  // ---------------------------------------------------------------- FIFO
  logic [31:0]         r_mem [c_DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr, w_count;
  logic                w_empty, w_full, w_flush, w_push, w_pop, w_drop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == c_DEPTH);
  assign w_flush = w_wr_ctrl & i_wb_dat[0];
  assign w_push  = r_push_pend & ~w_full & ~w_flush;
  assign w_drop  = r_push_pend &  w_full & ~w_flush;
  assign w_pop   = w_rd_rx & ~w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= r_rx_shift;
  end

  // ---------------------------------------------------------------- TX
  logic [31:0] r_tx_shift, r_tx_hold;
  logic        r_tx_pend, w_tx_load;

  // The next word is loaded on the sclk fall that follows the 32nd rise, so
  // its MSB is on MISO before the master's next sampling edge.
  assign w_tx_load = w_cs_rise | (w_tx_fall & (r_bit_cnt == 5'd0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_shift <= 32'h0;
      r_tx_hold  <= 32'h0;
      r_tx_pend  <= 1'b0;
    end else begin
      if (w_tx_load)      r_tx_shift <= r_tx_pend ? r_tx_hold : 32'h0;
      else if (w_tx_fall) r_tx_shift <= {r_tx_shift[30:0], 1'b0};
      if (w_wr_tx) begin
        r_tx_hold <= i_wb_dat;
        r_tx_pend <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_pend <= 1'b0;
      end
    end
  end

  assign o_miso = r_tx_shift[31];

  // ---------------------------------------------------------------- flags
  logic r_ovf, r_udf, r_irq_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_drop)                        r_ovf <= 1'b1;
      else if (w_wr_ctrl && i_wb_dat[1]) r_ovf <= 1'b0;
      if (w_rd_rx && w_empty)            r_udf <= 1'b1;
      else if (w_wr_ctrl && i_wb_dat[2]) r_udf <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic r_irq;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= i_wb_dat[3];
      r_irq <= r_irq_en & (~w_empty | r_ovf);
    end
  end
  assign o_irq = r_irq;
`else
  assign r_irq_en = 1'b0;
`endif

  // ---------------------------------------------------------------- read mux
  logic [5:0]  w_cnt6;
  logic [31:0] w_rd_val;

  always_comb begin
    w_cnt6 = 6'd0;
    w_cnt6[DEPTH_LOG2:0] = w_count;
  end

  always_comb begin
    w_rd_val = 32'h0;
    case (w_sel)
      c_RXDATA: w_rd_val = w_empty ? 32'h0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      c_TXDATA: w_rd_val = r_tx_hold;
      c_STATUS: w_rd_val = {18'b0, w_cnt6, 3'b0, r_tx_pend, r_udf, r_ovf,
                            w_full, w_empty};
      c_CTRL:   w_rd_val = {28'b0, r_irq_en, 3'b0};
      default:  w_rd_val = 32'h0;
    endcase
  end

  logic [31:0] r_wb_dat;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack    <= 1'b0;
      r_wb_dat <= 32'h0;
    end else begin
      r_ack    <= w_req;
      r_wb_dat <= (w_req && !i_wb_we) ? w_rd_val : 32'h0;
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_wb_dat;

  logic w_unused;
  assign w_unused = &{1'b0, i_wb_adr[1:0], r_mosi_sy[2]};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_wb
// Description : Self-checking bench for spi_slave_wb with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_wb;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int HALF  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, sclk = 1'b0, mosi = 1'b0, miso;
  logic [3:0]  adr = 4'h0;
  logic [31:0] wdat = 32'h0, rdat;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, ack;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] q[$];
  logic        m_ovf, m_udf, m_pend, m_irq_en;
  logic [31:0] m_hold;

  always #5 clk = ~clk;

  spi_slave_wb #(.DEPTH_LOG2(DL)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sclk(sclk), .i_mosi(mosi),
    .o_miso(miso), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_ack(ack)
`ifdef SPI_SLAVE_IRQ_EN
    , .o_irq(irq)
`endif
  );
`ifndef SPI_SLAVE_IRQ_EN
  assign irq = 1'b0;
`endif

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_pend = 0; m_hold = 0; m_irq_en = 0;
  endfunction

  function automatic logic [31:0] take();
    take = m_pend ? m_hold : 32'h0;
    m_pend = 0;
  endfunction

  function automatic void model_push(input logic [31:0] w);
    if (q.size() < DEPTH) q.push_back(w);
    else m_ovf = 1;
  endfunction

  function automatic logic [31:0] model_pop();
    if (q.size() == 0) begin
      m_udf = 1;
      return 32'h0;
    end
    return q.pop_front();
  endfunction

  function automatic logic [31:0] exp_status();
    int c = q.size();
    return (32'(c) << 8) | {27'b0, m_pend, m_udf, m_ovf, c == DEPTH, c == 0};
  endfunction

  task automatic wb_cycle(input logic w, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] r);
    bit got = 0;
    @(negedge clk);
    adr = a; we = w; wdat = d; cyc = 1; stb = 1;
    r = 32'hx;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin r = rdat; got = 1; end
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      $display("FAIL wb_ack_timeout: ack=0 required=1 adr=%h", a);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, dummy);
    if (a[3:2] == 2'd1) begin m_hold = d; m_pend = 1; end
    if (a[3:2] == 2'd3) begin
      if (d[0]) q.delete();
      if (d[1]) m_ovf = 0;
      if (d[2]) m_udf = 0;
`ifdef SPI_SLAVE_IRQ_EN
      m_irq_en = d[3];
`endif
    end
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] r);
    wb_cycle(1'b0, a, 32'h0, r);
  endtask

  task automatic cs_start();
    @(negedge clk); cs = 1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk); cs = 0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n, output logic [31:0] m);
    m = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); mosi = w[31-i];
      repeat (HALF - 1) @(negedge clk);
      m = {m[30:0], miso};
      sclk = 1;
      repeat (HALF) @(negedge clk);
      sclk = 0;
    end
  endtask

  // Last bit's rise is aligned so the bus request lands on the push cycle.
  task automatic spi_word_op(input logic [31:0] w, input logic bwe, input logic [3:0] a,
                             input logic [31:0] d, output logic [31:0] r);
    logic [31:0] m;
    spi_bits(w, 31, m);
    @(negedge clk); mosi = w[0];
    repeat (HALF - 1) @(negedge clk);
    sclk = 1;
    repeat (3) @(negedge clk);
    adr = a; we = bwe; wdat = d; cyc = 1; stb = 1;
    @(posedge clk); #1;
    r = rdat;
    if (!ack) begin
      $display("FAIL op_ack: ack=%b required=1", ack);
      n_bad++;
    end
    n_cmp++;
    cyc = 0; stb = 0; we = 0;
    repeat (HALF) @(negedge clk);
    sclk = 0;
  endtask

  task automatic check_status(input string name);
    logic [31:0] s;
    wb_read(4'h8, s);
    if (s !== exp_status()) begin
      $display("FAIL %s: status=%h required=%h", name, s, exp_status());
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic drain(input string name);
    logic [31:0] r, e;
    while (q.size() > 0) begin
      e = model_pop();
      wb_read(4'h0, r);
      if (r !== e) begin
        $display("FAIL %s: rxdata=%h required=%h", name, r, e);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; cs = 0; sclk = 0; mosi = 0;
    repeat (3) @(negedge clk); rst = 0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    if ({miso, ack, rdat, irq} !== 35'h0) begin
      $display("FAIL reset_outputs: got %h required 0", {miso, ack, rdat, irq});
      n_bad++;
    end
    n_cmp++;
    check_status("reset_status");
    wb_read(4'h4, r);
    @(posedge clk); #1;
    if (ack !== 1'b0) begin
      $display("FAIL ack_one_cycle: ack=%b required=0", ack);
      n_bad++;
    end
    n_cmp++;
    if (r !== 32'h0) begin
      $display("FAIL reset_txhold: got %h required 0", r);
      n_bad++;
    end
    n_cmp++;
    wb_read(4'hC, r);
    if (r !== 32'h0) begin
      $display("FAIL reset_ctrl: got %h required 0", r);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_rx_basic();
    logic [31:0] m;
    cs_start();
    spi_bits(32'h0000_0301, 32, m);
    cs_end();
    model_push(32'h0000_0301);
    check_status("rx_basic_count");
    drain("rx_basic_data");
    check_status("rx_basic_empty");
  endtask

  task automatic test_tx();
    logic [31:0] m, e, r;
    wb_write(4'h4, 32'hA5A5_5A5A);
    wb_read(4'h4, r);
    if (r !== 32'hA5A5_5A5A) begin
      $display("FAIL tx_readback: got %h required a5a55a5a", r);
      n_bad++;
    end
    n_cmp++;
    cs_start(); e = take();
    spi_bits(32'hFFFF_FFFF, 32, m); model_push(32'hFFFF_FFFF);
    if (m !== e) begin
      $display("FAIL tx_word1: miso=%h required=%h", m, e);
      n_bad++;
    end
    n_cmp++;
    e = take();
    spi_bits(32'h1357_9BDF, 32, m); model_push(32'h1357_9BDF);
    if (m !== e) begin
      $display("FAIL tx_word2: miso=%h required=%h", m, e);
      n_bad++;
    end
    n_cmp++;
    void'(take());
    cs_end();
    check_status("tx_pend_clear");
    drain("tx_rx");
  endtask

  task automatic test_random();
    logic [31:0] m, e, w;
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(0, 1) == 1) wb_write(4'h4, $urandom);
      cs_start(); e = take();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        w = $urandom;
        spi_bits(w, 32, m); model_push(w);
        if (m !== e) begin
          $display("FAIL rand_miso: miso=%h required=%h", m, e);
          n_bad++;
        end
        n_cmp++;
        e = take();
      end
      cs_end();
      check_status("rand_status");
      drain("rand_data");
    end
  endtask

  task automatic test_overflow();
    logic [31:0] m;
    cs_start(); void'(take());
    for (int k = 0; k <= DEPTH; k++) begin
      spi_bits(32'hC0DE_0000 + k, 32, m);
      model_push(32'hC0DE_0000 + k);
      void'(take());
    end
    cs_end();
    check_status("ovf_full");
    drain("ovf_order");
    wb_write(4'hC, 32'h2);
    check_status("ovf_clear");
  endtask

  task automatic test_partial();
    logic [31:0] m;
    cs_start(); void'(take());
    spi_bits($urandom, 12, m);
    cs_end();
    cs_start(); void'(take());
    spi_bits(32'h1234_5678, 32, m); model_push(32'h1234_5678); void'(take());
    cs_end();
    check_status("partial_status");
    drain("partial_data");
  endtask

  task automatic test_underflow();
    logic [31:0] r, e;
    e = model_pop();
    wb_read(4'h0, r);
    if (r !== e) begin
      $display("FAIL udf_data: got %h required %h", r, e);
      n_bad++;
    end
    n_cmp++;
    check_status("udf_set");
    wb_write(4'hC, 32'h4);
    check_status("udf_clear");
  endtask

  task automatic test_push_pop();
    logic [31:0] m, r, e, wa, wb;
    wa = $urandom; wb = $urandom;
    cs_start(); void'(take());
    spi_bits(wa, 32, m); model_push(wa); void'(take());
    e = model_pop();
    spi_word_op(wb, 1'b0, 4'h0, 32'h0, r); model_push(wb); void'(take());
    cs_end();
    if (r !== e) begin
      $display("FAIL pushpop_data: got %h required %h", r, e);
      n_bad++;
    end
    n_cmp++;
    check_status("pushpop_count");
    drain("pushpop_new");
    cs_start(); void'(take());
    spi_bits($urandom, 32, m); model_push(m); void'(take());
    spi_word_op($urandom, 1'b1, 4'hC, 32'h1, r); q.delete(); void'(take());
    cs_end();
    check_status("flush_wins");
  endtask

  task automatic test_reset_midword();
    logic [31:0] m;
    cs_start(); void'(take());
    spi_bits($urandom, 12, m);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk); rst = 0;
    model_reset();
    @(negedge clk);
    if ({miso, ack, rdat, irq} !== 35'h0) begin
      $display("FAIL rst_mid_outputs: got %h required 0", {miso, ack, rdat, irq});
      n_bad++;
    end
    n_cmp++;
    spi_bits($urandom, 20, m);
    cs_end();
    check_status("rst_mid_discard");
    cs_start(); void'(take());
    spi_bits(32'hBEEF_0042, 32, m); model_push(32'hBEEF_0042); void'(take());
    cs_end();
    check_status("rst_mid_resume");
    drain("rst_mid_data");
  endtask

`ifdef SPI_SLAVE_IRQ_EN
  task automatic test_irq();
    logic [31:0] m, r;
    wb_write(4'hC, 32'h8);
    wb_read(4'hC, r);
    if (r !== 32'h8) begin
      $display("FAIL irq_ctrl_read: got %h required 8", r);
      n_bad++;
    end
    n_cmp++;
    cs_start(); void'(take());
    spi_bits(32'h0BAD_F00D, 32, m); model_push(32'h0BAD_F00D); void'(take());
    cs_end();
    if (irq !== 1'b1) begin
      $display("FAIL irq_set: irq=%b required=1", irq);
      n_bad++;
    end
    n_cmp++;
    wb_read(4'h0, r); void'(model_pop());
    @(posedge clk); #1;
    if (irq !== 1'b0) begin
      $display("FAIL irq_clear: irq=%b required=0", irq);
      n_bad++;
    end
    n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_rx_basic();
    test_tx();
    test_random();
    test_overflow();
    test_partial();
    test_underflow();
    test_push_pop();
`ifdef SPI_SLAVE_IRQ_EN
    test_irq();
`endif
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_wb.md
# spi_slave_wb

Wishbone-attached SPI slave peripheral that sits directly downstream of the external SPI master. It sits inside the SoC between the top-level SPI pins and the RISC-V data bus. The block samples the SPI pins in the system clock domain and assembles 32-bit MSB-first words into an RX FIFO that the CPU pops over Wishbone. In parallel, it shifts a CPU-loaded TX word out on MISO.

## Interface
- `DEPTH_LOG2`, default 3: RX FIFO depth is 2^DEPTH_LOG2 words. Legal range is 1..5.
- `i_clk`  in  1: system clock; all logic is on its rising edge.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_cs`  in  1: chip select, active-high; the top level already inverts the pin. Asynchronous to `i_clk`.
- `i_sclk`  in  1: SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous.
- `i_mosi`  in  1: serial data in, MSB first. Asynchronous.
- `o_miso`  out  1: serial data out, MSB first.
- `i_wb_adr`  in  4: byte address; bits [3:2] select the register.
- `i_wb_dat`  in  32: write data.
- `o_wb_dat`  out  32: read data.
- `i_wb_we`, `i_wb_cyc`, `i_wb_stb`  in  1 each: classic Wishbone controls.
- `o_wb_ack`  out  1: single-cycle acknowledge.
- `o_irq`  out  1: level interrupt; this port exists only with `SPI_SLAVE_IRQ_EN`.

## Operation
- Synchronisers: `i_cs`, `i_sclk` and `i_mosi` each pass through 2 flops, plus a third stage for edge detection.
- A rise or fall event is a 1-cycle pulse.
- RX path: on each sclk rise while cs is high, shift mosi into `rx_shift` from the LSB end and increment the 5-bit `bit_cnt`.
- When `bit_cnt` wraps 31→0, the completed word is pushed into the FIFO on the next cycle.
- If the FIFO is full, the word is dropped and sticky `ovf` is set.
- On cs fall, a partial word is discarded and `bit_cnt` is cleared. On cs rise, `bit_cnt` is cleared.
- TX path: `tx_hold` is loaded by a CPU write, which sets `tx_pend`.
- At cs rise and at each word boundary, `tx_shift` takes `tx_hold` if `tx_pend` is set and clears `tx_pend`; otherwise it loads 32'h0.
- `o_miso` presents `tx_shift[31]`. It shifts left on each sclk fall while cs is high.
- Registers (word offset):
  - 0x0 RXDATA (read): pops the FIFO head. If the FIFO is empty, the read returns 0 and sets sticky `udf`.
  - 0x4 TXDATA (write): loads `tx_hold`. A read returns `tx_hold`.
  - 0x8 STATUS (read): {`rx_count`[5:0] at bits [13:8], `tx_pend`[4], `udf`[3], `ovf`[2], `rx_full`[1], `rx_empty`[0]}.
  - 0xC CTRL (write):
    - bit0 flushes the FIFO.
    - bit1 clears `ovf`.
    - bit2 clears `udf`.
    - bit3 sets `irq_en` (with macro only).
  - CTRL read returns {`irq_en`, 3'b0}.
- Writes to read-only offsets and reads of write-only bits are ignored or return 0.

## Timing
- Reset state:
  - `o_miso`=0, `o_wb_ack`=0, `o_wb_dat`=0, `o_irq`=0.
  - FIFO empty with pointers at 0; `bit_cnt`=0.
  - `tx_hold`=0, `tx_pend`=0, `ovf`=0, `udf`=0, `irq_en`=0.
  - Synchroniser flops are cleared.
- Reset asserted during a transfer aborts the transfer. Reception resumes only after the next cs rise.
- Pin-to-event latency is 3 `i_clk` cycles. The required ratio is `i_sclk` period ≥ 8 `i_clk` periods.
- Last sclk rise to FIFO visibility (`rx_count` increment) is 4 cycles.
- Wishbone handshake:
  - `o_wb_ack` rises the cycle after `cyc&stb` and lasts 1 cycle.
  - No new request is accepted in the ack cycle.
  - Read data and side effects (pop, `tx_hold` load, clears) take effect in the ack cycle.
- Push and pop in the same cycle: both occur and the count is unchanged.
- Flush in the same cycle as a push: the flush wins and the FIFO ends empty.
- A TXDATA write in the same cycle as a word-boundary load: `tx_shift` takes the old `tx_hold`. The new value stays pending.
- Pointers are DEPTH_LOG2+1 bits with the wrap bit. Full is reached when `rx_count`==2^DEPTH_LOG2.

## Configuration
- `SPI_SLAVE_IRQ_EN`:
  - Defined: `o_irq` port and `irq_en` bit exist. `o_irq` is registered and equals `irq_en & (!rx_empty | ovf)`, with 1 cycle of latency.
  - Undefined: the port is absent, CTRL bit3 is ignored, and CTRL reads 0.

## Test plan
- Master sends 32'h00000301 with cs high and SCLK at clk/8 → STATUS reads `rx_count`=1. RXDATA returns 32'h00000301. STATUS then shows `rx_empty`=1.
- CPU writes TXDATA=32'hA5A5_5A5A, then the master sends 32'hFFFFFFFF → the master receives 32'hA5A5_5A5A. After the word, `tx_pend`=0. A second word returns 32'h0.
- Master sends 9 words with depth 8 → `rx_full`=1 and `ovf`=1. Words 1..8 read back in order and the 9th is lost. CTRL=0x2 clears `ovf`.
- cs drops after 12 bits, then a full word 32'h12345678 follows → the FIFO holds only 32'h12345678.
- RXDATA read on an empty FIFO → returns 0 and `udf`=1. A simultaneous word completion and RXDATA pop with 1 entry → `rx_count` stays 1.
- With `SPI_SLAVE_IRQ_EN`: CTRL=0x8, then one word received → `o_irq`=1. Popping the word → `o_irq`=0 one cycle after ack. Asserting `i_rst` mid-word → the partial word is discarded and all outputs return to 0.
